alu_arbiter: RTL

Shares the single 8-bit ALU between two requesters (port 0, port 1) with round-robin arbitration. It sequences each operation through the ALU's registered-result, tri-state-output protocol: load operands and assert the execute enable, then enable the output onto the bus and capture it. It returns the result and locally derived flags to the winning requester with a one-cycle done pulse. It sits between the ALU and its clients (CPU control unit, address/loop unit) and is the only driver of the ALU's control inputs.

---
 rtl/alu_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered-result, tri-state-output ALU between two requesters.
module alu_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_req,
    input  logic [2:0]   r0_mode,
    input  logic [W-1:0] r0_a,
    input  logic [W-1:0] r0_b,
    output logic         r0_gnt,
    output logic         r0_done,
    input  logic         r1_req,
    input  logic [2:0]   r1_mode,
    input  logic [W-1:0] r1_a,
    input  logic [W-1:0] r1_b,
    output logic         r1_gnt,
    output logic         r1_done,
    output logic [W-1:0] res,
    output logic         res_zero,
    output logic         res_carry,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_mode,
    output logic         alu_ee,
    output logic         alu_eo,
    input  logic [W-1:0] alu_bus,
    input  logic         alu_carry
);
    typedef enum logic [1:0] {IDLE, ISSUE, READ, DONE} state_t;
    state_t state, state_n;
    logic last, win, pick, any;
    assign any  = r0_req | r1_req;
    assign pick = (r0_req & r1_req) ? ~last : r1_req;
    always_comb begin
        state_n = state;
        state_n = state == IDLE  ? (any ? ISSUE : IDLE) :
                  state == ISSUE ? READ :
                  state == READ  ? DONE : IDLE;
    end
    // Control outputs are flops loaded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            win       <= 1'b0;
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_done   <= 1'b0;
            r1_done   <= 1'b0;
            alu_ee    <= 1'b0;
            alu_eo    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_mode  <= '0;
            res       <= '0;
            res_zero  <= 1'b0;
            res_carry <= 1'b0;
        end else begin
            state   <= state_n;
            alu_ee  <= state_n == ISSUE;
            alu_eo  <= state_n == READ;
            r0_gnt  <= state_n == ISSUE && !pick;
            r1_gnt  <= state_n == ISSUE && pick;
            r0_done <= state_n == DONE && !win;
            r1_done <= state_n == DONE && win;
            if (state == IDLE && any) begin
                win      <= pick;
                last     <= pick;
                alu_mode <= pick ? r1_mode : r0_mode;
                alu_a    <= pick ? r1_a : r0_a;
                alu_b    <= pick ? r1_b : r0_b;
            end
            // Zero is derived locally; the ALU's own zero flag is sticky.
            if (state == READ) begin
                res       <= alu_bus;
                res_zero  <= alu_bus == '0;
                res_carry <= (alu_mode <= 3'd2) & alu_carry;
            end
        end
    end
endmodule
